// File: rtl/imem_load_arbiter.sv
// Instruction memory port owner: CPU fetch in RUN, loader streaming writes in LOAD,
// and a one-cycle FLUSH that reports the load and restarts the CPU at PC 0.
module imem_load_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 16,
    parameter int BOOT_LOAD = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [15:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_data,
    output logic          fetch_fault,
    output logic          cpu_hold,
    output logic          pc_restart,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic [AW:0]   load_count,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH} state_e;

    localparam state_e RST_STATE = (BOOT_LOAD != 0) ? S_LOAD : S_RUN;
    localparam logic   RST_HOLD  = (BOOT_LOAD != 0);

    state_e        state_q, state_d;
    // One bit wider than the address so a full 2^AW-word load can be counted.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic          fetch_valid_q, fetch_fault_q, cpu_hold_q;
    logic          pc_restart_q, ld_done_q;
    logic [DW-1:0] fetch_data_q;
    logic [AW:0]   load_count_q;
    logic          addr_fault;
    logic          enter_flush;

    assign addr_fault  = |fetch_addr[15:AW];
    assign enter_flush = (state_d == S_FLUSH);
    assign mem_wdata   = ld_data;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fetch_gnt = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_addr[AW-1:0];
        case (state_q)
            S_RUN: begin
                fetch_gnt = fetch_req;
                if (ld_start) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end
            end
            S_LOAD: begin
                mem_addr = wr_ptr_q[AW-1:0];
                ld_ready = !ld_start;
                if (ld_start) begin
                    wr_ptr_d = '0;
                end else if (ld_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Last word either flagged by the loader or forced by a full memory.
                    if (ld_last || (&wr_ptr_q[AW-1:0]))
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                mem_addr = wr_ptr_q[AW-1:0];
                state_d  = S_RUN;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_STATE;
            wr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= '0;
            cpu_hold_q    <= RST_HOLD;
            pc_restart_q  <= 1'b0;
            ld_done_q     <= 1'b0;
            load_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            fetch_valid_q <= fetch_gnt;
            fetch_fault_q <= fetch_gnt & addr_fault;
            if (fetch_gnt)
                fetch_data_q <= addr_fault ? '0 : mem_rdata;
            cpu_hold_q    <= (state_d != S_RUN);
            pc_restart_q  <= enter_flush;
            ld_done_q     <= enter_flush;
            if (enter_flush)
                load_count_q <= wr_ptr_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_data  = fetch_data_q;
    assign cpu_hold    = cpu_hold_q;
    assign pc_restart  = pc_restart_q;
    assign ld_done     = ld_done_q;
    assign load_count  = load_count_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: a RUN-booting instance with a behavioural memory,
// plus a LOAD-booting instance used for the reset-during-load cases.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_b_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [15:0] ld_data = '0;

    logic        fetch_gnt, fetch_valid, fetch_fault, cpu_hold, pc_restart;
    logic        ld_ready, ld_done, mem_we;
    logic [15:0] fetch_data, mem_wdata, mem_rdata;
    logic [6:0]  load_count;
    logic [5:0]  mem_addr;

    logic        b_fetch_gnt, b_fetch_valid, b_fetch_fault, b_cpu_hold, b_pc_restart;
    logic        b_ld_ready, b_ld_done, b_mem_we;
    logic [15:0] b_fetch_data, b_mem_wdata, b_rdata;
    logic [6:0]  b_load_count;
    logic [5:0]  b_mem_addr;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    // Memory written only by the DUT, except the bench's preload port.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end
    assign mem_rdata = mem[mem_addr];
    assign b_rdata   = 16'h0;

    imem_load_arbiter #(.AW(6), .DW(16), .BOOT_LOAD(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
        .cpu_hold(cpu_hold), .pc_restart(pc_restart),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .load_count(load_count),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_load_arbiter #(.AW(6), .DW(16), .BOOT_LOAD(1)) u_boot (
        .clk(clk), .rst_n(rst_b_n),
        .fetch_req(1'b0), .fetch_addr(fetch_addr), .fetch_gnt(b_fetch_gnt),
        .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_fault(b_fetch_fault),
        .cpu_hold(b_cpu_hold), .pc_restart(b_pc_restart),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(b_ld_ready), .ld_done(b_ld_done), .load_count(b_load_count),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change 2 units after the rising edge; checks run 2 units later.
    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    // Streams n words with random gaps; the word at slot k is expected at address k.
    task automatic load_words(input int n, input bit last_en, input bit seq);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 1000) begin
            nxt;
            ld_start = 1'b0;
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_data  = seq ? 16'(sent + 1) : 16'($urandom);
            ld_last  = last_en && (sent == n - 1);
            #2;
            chk("ld_ready", ld_ready, 1);
            chk("ld_gnt", fetch_gnt, 0);
            chk("ld_we", mem_we, ld_valid);
            chk("ld_addr", mem_addr, sent % 64);
            chk("ld_hold", cpu_hold, 1);
            if (ld_valid) begin
                ref_mem[sent % 64] = ld_data;
                sent++;
            end
            guard++;
        end
        if (guard >= 1000) chk("ld_timeout", 0, 1);
    endtask

    // FLUSH cycle (ld_start there must be ignored), then first RUN cycle fetching addr 1.
    task automatic flush_chk(input int n);
        nxt;
        ld_valid = 1'b1; ld_last = 1'b0; ld_start = 1'b1;
        #2;
        chk("fl_done", ld_done, 1);
        chk("fl_pcr", pc_restart, 1);
        chk("fl_count", load_count, n);
        chk("fl_hold", cpu_hold, 1);
        chk("fl_ready", ld_ready, 0);
        chk("fl_we", mem_we, 0);
        chk("fl_gnt", fetch_gnt, 0);
        nxt;
        ld_start = 1'b0; ld_valid = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'd1;
        #2;
        chk("run_hold", cpu_hold, 0);
        chk("run_done", ld_done, 0);
        chk("run_pcr", pc_restart, 0);
        chk("run_gnt", fetch_gnt, 1);
        nxt;
        fetch_req = 1'b0;
        #2;
        chk("run_vld", fetch_valid, 1);
        chk("run_data", fetch_data, ref_mem[1]);
    endtask

    task automatic fetch_sweep;
        logic        pv = 1'b0;
        logic [15:0] pd = '0;
        for (int i = 0; i <= 64; i++) begin
            nxt;
            fetch_req  = (i < 64);
            fetch_addr = 16'(i % 64);
            #2;
            chk("sweep_vld", fetch_valid, pv);
            if (pv) chk("sweep_data", fetch_data, pd);
            pv = (i < 64);
            pd = ref_mem[i % 64];
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        logic        pv, pf, r;
        logic [15:0] pd, a;
        int          k, n;

        // Preload memory while both instances are held in reset.
        for (int i = 0; i < 64; i++) begin
            nxt;
            pl_we   = 1'b1;
            pl_addr = 6'(i);
            pl_data = (i == 3) ? 16'h1234 : (i == 4) ? 16'hA5C1 : 16'($urandom);
            ref_mem[i] = pl_data;
        end
        nxt;
        pl_we = 1'b0;
        #2;
        chk("rst_vld", fetch_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_data", fetch_data, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_pcr", pc_restart, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_count", load_count, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_b_hold", b_cpu_hold, 1);
        chk("rst_b_ready", b_ld_ready, 1);
        nxt;
        rst_n = 1'b1;

        // Directed back-to-back fetches and an out-of-range address.
        nxt; fetch_req = 1'b1; fetch_addr = 16'd3; #2;
        chk("f_gnt", fetch_gnt, 1);
        chk("f_raddr", mem_addr, 3);
        chk("f_we", mem_we, 0);
        nxt; fetch_addr = 16'd4; #2;
        chk("f3_vld", fetch_valid, 1);
        chk("f3_data", fetch_data, 16'h1234);
        chk("f3_fault", fetch_fault, 0);
        nxt; fetch_addr = 16'h0040; #2;
        chk("f4_vld", fetch_valid, 1);
        chk("f4_data", fetch_data, 16'hA5C1);
        nxt; fetch_req = 1'b0; #2;
        chk("f40_vld", fetch_valid, 1);
        chk("f40_fault", fetch_fault, 1);
        chk("f40_data", fetch_data, 0);
        nxt; #2;
        chk("idle_vld", fetch_valid, 0);

        // Random fetch stream against the reference memory.
        pv = 1'b0; pf = 1'b0; pd = '0;
        repeat (40) begin
            nxt;
            r = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0040) : 16'($urandom_range(0, 63));
            fetch_req = r; fetch_addr = a;
            #2;
            chk("rnd_gnt", fetch_gnt, r);
            chk("rnd_ready", ld_ready, 0);
            chk("rnd_vld", fetch_valid, pv);
            if (pv) begin
                chk("rnd_data", fetch_data, pd);
                chk("rnd_fault", fetch_fault, pf);
            end
            pv = r;
            pf = (a[15:6] != 0);
            pd = pf ? 16'h0 : ref_mem[a[5:0]];
        end
        nxt; fetch_req = 1'b0; #2;
        chk("rnd_vld_end", fetch_valid, pv);
        if (pv) chk("rnd_data_end", fetch_data, pd);

        // Load start collides with a granted fetch of addr 5; 3-word load with gaps.
        nxt; fetch_req = 1'b1; fetch_addr = 16'd5; ld_start = 1'b1; #2;
        chk("col_gnt", fetch_gnt, 1);
        chk("col_ready", ld_ready, 0);
        nxt; ld_start = 1'b0; #2;
        chk("col_vld", fetch_valid, 1);
        chk("col_data", fetch_data, ref_mem[5]);
        chk("col_hold", cpu_hold, 1);
        chk("col_gnt2", fetch_gnt, 0);
        chk("col_addr", mem_addr, 0);
        load_words(3, 1'b1, 1'b1);
        flush_chk(3);
        chk("ld3_data", fetch_data, 16'h0002);

        // Restart mid-load: earlier words stay, new load begins at address 0.
        k = $urandom_range(2, 8);
        n = $urandom_range(1, 20);
        nxt; ld_start = 1'b1; #2;
        load_words(k, 1'b0, 1'b0);
        nxt; ld_start = 1'b1; ld_valid = 1'b1; ld_data = 16'hDEAD; #2;
        chk("rs_ready", ld_ready, 0);
        chk("rs_we", mem_we, 0);
        load_words(n, 1'b1, 1'b0);
        flush_chk(n);
        fetch_sweep;

        // Full-memory load without ld_last.
        nxt; ld_start = 1'b1; #2;
        load_words(64, 1'b0, 1'b0);
        flush_chk(64);
        fetch_sweep;

        // BOOT_LOAD instance: async reset after 10 words, then during FLUSH.
        nxt; rst_b_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nxt; ld_valid = 1'b1; ld_last = 1'b0; ld_data = 16'($urandom); #2;
            chk("b_addr", b_mem_addr, i);
            chk("b_we", b_mem_we, 1);
        end
        nxt; ld_valid = 1'b0; #2;
        chk("b_addr10", b_mem_addr, 10);
        rst_b_n = 1'b0; #1;
        chk("b_rst_addr", b_mem_addr, 0);
        chk("b_rst_hold", b_cpu_hold, 1);
        chk("b_rst_ready", b_ld_ready, 1);
        chk("b_rst_count", b_load_count, 0);
        nxt; rst_b_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt; ld_valid = 1'b1; ld_last = (i == 2); #2;
            chk("b2_addr", b_mem_addr, i);
        end
        nxt; ld_valid = 1'b0; ld_last = 1'b0; #2;
        chk("b_fl_done", b_ld_done, 1);
        chk("b_fl_pcr", b_pc_restart, 1);
        chk("b_fl_count", b_load_count, 3);
        rst_b_n = 1'b0; #1;
        chk("b_async_done", b_ld_done, 0);
        chk("b_async_pcr", b_pc_restart, 0);
        chk("b_async_count", b_load_count, 0);
        chk("b_async_hold", b_cpu_hold, 1);
        chk("b_async_vld", b_fetch_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
